// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial add/subtract controller.
package serial_add_ctrl_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

endpackage

// File: rtl/fulladder.sv
// 1-bit full adder cell.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder evaluation per clock, LSB first,
// with a valid/ready handshake on both the operand and result sides.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cin_last_q, cin_last_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             fa_sum, fa_carry;
  logic [WIDTH:0]   res_shift;

  fulladder u_fulladder (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  assign res_shift = {fa_sum, res_q};

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    carry_d    = carry_q;
    cin_last_d = cin_last_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StAdd;
          a_d     = op_a;
          b_d     = op_b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
        end
      end
      StAdd: begin
        a_d        = a_q >> 1;
        b_d        = b_q >> 1;
        res_d      = res_shift[WIDTH:1];
        carry_d    = fa_carry;
        cin_last_d = carry_q;
        cnt_d      = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      cin_last_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      cin_last_q <= cin_last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = res_q;
  assign cout      = carry_q;
  // Overflow: carry into the MSB differs from carry out of it.
  assign ovf       = cin_last_q ^ carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: vector table at WIDTH=8, hold/reset
// sequences, and an exhaustive WIDTH=1 sweep.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [7:0] op_a, op_b, result;

  logic       in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
  logic [0:0] a1, b1, res1;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .op_a      (a1),
    .op_b      (b1),
    .cin       (cin1),
    .sub       (sub1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .result    (res1),
    .cout      (cout1),
    .ovf       (ovf1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Latency is counted in rising edges after the capture edge.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 0; i <= 20; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic s);
    op_a     = a;
    op_b     = b;
    cin      = c;
    sub      = s;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    start_op(v.a, v.b, v.cin, v.sub);
    check({tag, " in_ready in ADD"}, in_ready, 1'b0);
    wait_out(lat);
    check({tag, " latency"}, lat, 8);
    check({tag, " result"}, result, v.res);
    check({tag, " cout"}, cout, v.cout);
    check({tag, " ovf"}, ovf, v.ovf);
    @(negedge clk);
    check({tag, " in_ready after"}, in_ready, 1'b1);
    check({tag, " out_valid after"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    logic seen;

    vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3]  = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{8'hC8, 8'hC8, 1'b0, 1'b0, 8'h90, 1'b1, 1'b0};
    vecs[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{8'h33, 8'h66, 1'b0, 1'b1, 8'hCD, 1'b0, 1'b0};
    vecs[10] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

    // Reset with in_valid high: reset must win.
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    op_a       = 8'h12;
    op_b       = 8'h34;
    cin        = 1'b0;
    sub        = 1'b0;
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;
    a1         = 1'b0;
    b1         = 1'b0;
    cin1       = 1'b0;
    sub1       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset result", result, 8'h00);
    check("reset cout", cout, 1'b0);
    check("reset ovf", ovf, 1'b0);

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Hold in DONE while inputs wiggle.
    out_ready = 1'b0;
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_out(lat);
    check("hold latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d result", i), result, 8'h96);
      check($sformatf("hold%0d cout", i), cout, 1'b0);
      check($sformatf("hold%0d ovf", i), ovf, 1'b1);
      check($sformatf("hold%0d out_valid", i), out_valid, 1'b1);
      check($sformatf("hold%0d in_ready", i), in_ready, 1'b0);
      op_a     = ~op_a;
      op_b     = 8'($urandom);
      in_valid = ~in_valid;
      sub      = ~sub;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("release in_ready before edge", in_ready, 1'b0);
    @(negedge clk);
    check("release in_ready after edge", in_ready, 1'b1);
    check("release out_valid after edge", out_valid, 1'b0);

    // Reset during the 4th ADD cycle.
    start_op(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort in_ready", in_ready, 1'b1);
    check("abort out_valid", out_valid, 1'b0);
    check("abort result", result, 8'h00);
    check("abort cout", cout, 1'b0);
    check("abort ovf", ovf, 1'b0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort no out_valid", seen, 1'b0);
    run_vec('{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0}, "post-abort");

    // Exhaustive WIDTH=1 sweep.
    for (int i = 0; i < 8; i++) begin
      logic a, b, c;
      int   l1;
      a         = i[2];
      b         = i[1];
      c         = i[0];
      a1        = a;
      b1        = b;
      cin1      = c;
      in_valid1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid1 = 1'b0;
      l1 = -1;
      for (int k = 0; k <= 10; k++) begin
        if (out_valid1) begin
          l1 = k;
          break;
        end
        @(posedge clk);
        @(negedge clk);
      end
      check($sformatf("w1 %0d latency", i), l1, 1);
      check($sformatf("w1 %0d result", i), res1, a ^ b ^ c);
      check($sformatf("w1 %0d cout", i), cout1, (a & b) | (a & c) | (b & c));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
